// File: rtl/reg_file_sb.sv
// reg_file_sb: general-purpose register file with a per-register scoreboard.
//
// The issue stage marks a destination pending (iss_en/iss_addr). Writeback
// (wr_en/wr_addr/wr_data) stores the data and clears the pending flag. Two
// combinational read ports return data plus a busy flag for RAW hazard
// detection. With BYPASS=1, same-cycle write data is forwarded to the reads.
// flush squashes every pending flag. busy_cnt is a registered count of the
// pending registers.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   rd_addr_1/2           read addresses
//   rd_data_1/2           read data (combinational)
//   rd_busy_1/2           read register has a pending write
//   wr_en/wr_addr/wr_data writeback
//   iss_en/iss_addr       issue: mark register pending
//   flush                 clear all pending flags
//   busy_cnt              number of pending registers (registered)

// One register plus its scoreboard bit. inc/dec report whether this cell's
// busy bit rises or falls at the next edge, which drives the shared counter.
module reg_file_sb_cell #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_hit,
    input  logic              iss_hit,
    input  logic              flush,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              inc,
    output logic              dec
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
            busy <= 1'b0;
        end else begin
            // Data is written even on flush; only the scoreboard is squashed.
            if (wr_hit)
                data <= wr_data;
            // Issue outranks a same-cycle writeback: a newer producer is in flight.
            if (flush)
                busy <= 1'b0;
            else if (iss_hit)
                busy <= 1'b1;
            else if (wr_hit)
                busy <= 1'b0;
        end
    end

    assign inc = !flush && iss_hit && !busy;
    assign dec = !flush && !iss_hit && wr_hit && busy;

endmodule

module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_busy_1,
    output logic              rd_busy_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              flush,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    typedef struct packed {
        logic              busy;
        logic [DATA_W-1:0] data;
    } rd_rsp_t;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             busy_vec;
    logic [DEPTH-1:0]             inc_vec;
    logic [DEPTH-1:0]             dec_vec;
    logic [1:0][ADDR_W-1:0]       rd_addr;
    logic                         inc;
    logic                         dec;

    // ---------------------------------------------------------------
    // Register cells
    // ---------------------------------------------------------------
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        logic wr_hit;
        logic iss_hit;

        // A hardwired zero register never sees a hit, so it keeps its
        // reset value of 0 and never becomes busy.
        if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
            assign wr_hit  = 1'b0;
            assign iss_hit = 1'b0;
        end else begin : g_norm
            assign wr_hit  = wr_en  && (wr_addr  == ADDR_W'(r));
            assign iss_hit = iss_en && (iss_addr == ADDR_W'(r));
        end

        reg_file_sb_cell #(
            .DATA_W (DATA_W)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_hit  (wr_hit),
            .iss_hit (iss_hit),
            .flush   (flush),
            .wr_data (wr_data),
            .data    (regs[r]),
            .busy    (busy_vec[r]),
            .inc     (inc_vec[r]),
            .dec     (dec_vec[r])
        );
    end

    // ---------------------------------------------------------------
    // Read ports: later assignments override earlier ones, so the
    // zero-register rule beats bypass, which beats the array.
    // ---------------------------------------------------------------
    assign rd_addr = {rd_addr_2, rd_addr_1};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        rd_rsp_t rsp;

        always_comb begin
            rsp.data = regs[rd_addr[p]];
            rsp.busy = busy_vec[rd_addr[p]];
            if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr[p])) begin
                rsp.data = wr_data;
                rsp.busy = 1'b0;
            end
            if ((ZERO_REG != 0) && (rd_addr[p] == '0))
                rsp = '0;
        end
    end

    assign rd_data_1 = g_rd[0].rsp.data;
    assign rd_busy_1 = g_rd[0].rsp.busy;
    assign rd_data_2 = g_rd[1].rsp.data;
    assign rd_busy_2 = g_rd[1].rsp.busy;

    // ---------------------------------------------------------------
    // Pending counter. At most one issue and one writeback per cycle,
    // so at most one cell raises inc and one raises dec; both at once
    // (different registers) net to zero. A cell never raises inc on an
    // already-busy bit, so the count cannot exceed the number of
    // registers and never wraps.
    // ---------------------------------------------------------------
    assign inc = |inc_vec;
    assign dec = |dec_vec;

    always_ff @(posedge clk) begin
        if (!rst_n)
            busy_cnt <= '0;
        else if (flush)
            busy_cnt <= '0;
        else if (inc && !dec)
            busy_cnt <= busy_cnt + CNT_ONE;
        else if (dec && !inc)
            busy_cnt <= busy_cnt - CNT_ONE;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb. Two instances run side by side:
//   A: DATA_W=16, ADDR_W=3, ZERO_REG=1, BYPASS=1 (defaults)
//   B: DATA_W=32, ADDR_W=5, ZERO_REG=0, BYPASS=0
// A reference model (plain arrays, busy count recomputed by popcount)
// tracks both and is advanced on every clock edge.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance A
    logic [2:0]  a_rd1, a_rd2, a_wa, a_ia;
    logic [15:0] a_rdd1, a_rdd2, a_wd;
    logic        a_bsy1, a_bsy2, a_wen, a_ien, a_flush;
    logic [3:0]  a_cnt;
    // instance B
    logic [4:0]  b_rd1, b_rd2, b_wa, b_ia;
    logic [31:0] b_rdd1, b_rdd2, b_wd;
    logic        b_bsy1, b_bsy2, b_wen, b_ien, b_flush;
    logic [5:0]  b_cnt;

    int vectors = 0;
    int miscompares = 0;

    reg_file_sb u_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_1(a_rd1), .rd_addr_2(a_rd2),
        .rd_data_1(a_rdd1), .rd_data_2(a_rdd2),
        .rd_busy_1(a_bsy1), .rd_busy_2(a_bsy2),
        .wr_en(a_wen), .wr_addr(a_wa), .wr_data(a_wd),
        .iss_en(a_ien), .iss_addr(a_ia), .flush(a_flush),
        .busy_cnt(a_cnt)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_1(b_rd1), .rd_addr_2(b_rd2),
        .rd_data_1(b_rdd1), .rd_data_2(b_rdd2),
        .rd_busy_1(b_bsy1), .rd_busy_2(b_bsy2),
        .wr_en(b_wen), .wr_addr(b_wa), .wr_data(b_wd),
        .iss_en(b_ien), .iss_addr(b_ia), .flush(b_flush),
        .busy_cnt(b_cnt)
    );

    // ---------------- reference model ----------------
    int          cfg_zr  [2] = '{1, 0};
    int          cfg_byp [2] = '{1, 0};
    logic [31:0] m_reg   [2][32];
    bit          m_busy  [2][32];

    function automatic void model_update(int i, logic wen, logic [4:0] wa, logic [31:0] wd,
                                         logic ien, logic [4:0] ia, logic fl);
        bit w_ok, i_ok;
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[i][r]  = '0;
                m_busy[i][r] = 1'b0;
            end
            return;
        end
        w_ok = wen && !(cfg_zr[i] != 0 && wa == 0);
        i_ok = ien && !(cfg_zr[i] != 0 && ia == 0);
        if (w_ok) m_reg[i][wa] = wd;
        if (fl) begin
            for (int r = 0; r < 32; r++) m_busy[i][r] = 1'b0;
        end else begin
            if (w_ok) m_busy[i][wa] = 1'b0;
            if (i_ok) m_busy[i][ia] = 1'b1;   // newer producer wins
        end
    endfunction

    // {busy, data} seen by a read port given the current inputs
    function automatic logic [32:0] model_rd(int i, logic [4:0] addr, logic wen,
                                             logic [4:0] wa, logic [31:0] wd);
        if (cfg_zr[i] != 0 && addr == 0) return '0;
        if (cfg_byp[i] != 0 && wen && wa == addr) return {1'b0, wd};
        return {m_busy[i][addr], m_reg[i][addr]};
    endfunction

    function automatic int model_cnt(int i);
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[i][r]);
        return c;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        a_wen = 0; a_wa = 0; a_wd = 0; a_ien = 0; a_ia = 0; a_flush = 0;
        b_wen = 0; b_wa = 0; b_wd = 0; b_ien = 0; b_ia = 0; b_flush = 0;
    endtask

    // Advance one clock edge; inputs are sampled by both DUT and model.
    task automatic step();
        @(posedge clk);
        model_update(0, a_wen, 5'(a_wa), 32'(a_wd), a_ien, 5'(a_ia), a_flush);
        model_update(1, b_wen, b_wa, b_wd, b_ien, b_ia, b_flush);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // writes/issues during reset must be ignored
        rst_n = 0; idle();
        a_wen = 1; a_wa = 3; a_wd = 16'h1234; a_ien = 1; a_ia = 3;
        b_wen = 1; b_wa = 7; b_wd = 32'hDEAD; b_ien = 1; b_ia = 7;
        step();
        rst_n = 1; idle();
        for (int r = 0; r < 8; r++) begin
            a_rd1 = 3'(r); a_rd2 = 3'(7 - r); #1;
            vectors++;
            if (a_rdd1 !== 16'h0 || a_bsy1 !== 1'b0 || a_rdd2 !== 16'h0 || a_bsy2 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_a r=%0d got=%h/%b %h/%b exp=0000/0", r, a_rdd1, a_bsy1, a_rdd2, a_bsy2);
            end
        end
        for (int r = 0; r < 32; r++) begin
            b_rd1 = 5'(r); b_rd2 = 5'(31 - r); #1;
            vectors++;
            if (b_rdd1 !== 32'h0 || b_bsy1 !== 1'b0 || b_rdd2 !== 32'h0 || b_bsy2 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_b r=%0d got=%h/%b %h/%b exp=0/0", r, b_rdd1, b_bsy1, b_rdd2, b_bsy2);
            end
        end
        vectors++;
        if (a_cnt !== 4'd0 || b_cnt !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", a_cnt, b_cnt);
        end
    endtask

    task automatic test_issue_wb();
        idle(); a_ien = 1; a_ia = 3; step();
        idle(); a_rd1 = 3; #1;
        vectors++;
        if (a_bsy1 !== 1'b1 || a_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL iss_busy got=%b cnt=%0d exp=1 cnt=1", a_bsy1, a_cnt);
        end
        step(); step(); step();
        a_wen = 1; a_wa = 3; a_wd = 16'hBEEF; #1;
        vectors++;
        if (a_rdd1 !== 16'hBEEF || a_bsy1 !== 1'b0 || a_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL wb_bypass got=%h/%b cnt=%0d exp=beef/0 cnt=1", a_rdd1, a_bsy1, a_cnt);
        end
        step(); idle(); #1;
        vectors++;
        if (a_rdd1 !== 16'hBEEF || a_bsy1 !== 1'b0 || a_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL wb_after got=%h/%b cnt=%0d exp=beef/0 cnt=0", a_rdd1, a_bsy1, a_cnt);
        end
    endtask

    task automatic test_collision();
        idle(); a_ien = 1; a_ia = 5; step();
        a_wen = 1; a_wa = 5; a_wd = 16'h1234; step();
        idle(); a_rd1 = 5; #1;
        vectors++;
        if (a_rdd1 !== 16'h1234 || a_bsy1 !== 1'b1 || a_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL coll_same got=%h/%b cnt=%0d exp=1234/1 cnt=1", a_rdd1, a_bsy1, a_cnt);
        end
        a_ien = 1; a_ia = 2; a_wen = 1; a_wa = 5; a_wd = 16'h5678; step();
        idle(); a_rd1 = 5; a_rd2 = 2; #1;
        vectors++;
        if (a_rdd1 !== 16'h5678 || a_bsy1 !== 1'b0 || a_bsy2 !== 1'b1 || a_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL coll_cross got=%h/%b/%b cnt=%0d exp=5678/0/1 cnt=1", a_rdd1, a_bsy1, a_bsy2, a_cnt);
        end
        a_wen = 1; a_wa = 2; a_wd = 16'h0002; step(); idle();
    endtask

    task automatic test_zero_reg();
        idle();
        a_wen = 1; a_wa = 0; a_wd = 16'hFFFF; b_wen = 1; b_wa = 0; b_wd = 32'hFFFF;
        a_rd1 = 0; b_rd1 = 0; #1;
        vectors++;   // bypass must not override the zero register
        if (a_rdd1 !== 16'h0 || a_bsy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_bypass got=%h/%b exp=0000/0", a_rdd1, a_bsy1);
        end
        step(); idle();
        a_ien = 1; a_ia = 0; b_ien = 1; b_ia = 0; step(); idle();
        a_rd1 = 0; a_rd2 = 0; b_rd1 = 0; b_rd2 = 0; #1;
        vectors++;
        if (a_rdd1 !== 16'h0 || a_bsy1 !== 1'b0 || a_rdd2 !== 16'h0 || a_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL zero_a got=%h/%b cnt=%0d exp=0000/0 cnt=0", a_rdd1, a_bsy1, a_cnt);
        end
        vectors++;
        if (b_rdd1 !== 32'hFFFF || b_bsy1 !== 1'b1 || b_rdd2 !== 32'hFFFF || b_cnt !== 6'd1) begin
            miscompares++;
            $display("FAIL nonzero_b got=%h/%b cnt=%0d exp=0000ffff/1 cnt=1", b_rdd1, b_bsy1, b_cnt);
        end
        b_wen = 1; b_wa = 0; b_wd = 32'h0; step(); idle();
    endtask

    task automatic test_flush();
        idle();
        a_ien = 1; a_ia = 1; step();
        a_ia = 2; step();
        a_ia = 4; step(); idle(); #1;
        vectors++;
        if (a_cnt !== 4'd3) begin
            miscompares++;
            $display("FAIL flush_pre cnt got=%0d exp=3", a_cnt);
        end
        a_flush = 1; a_ien = 1; a_ia = 6; a_wen = 1; a_wa = 2; a_wd = 16'h00AA; step(); idle();
        for (int r = 0; r < 8; r++) begin
            a_rd1 = 3'(r); #1;
            vectors++;
            if (a_bsy1 !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_busy r=%0d got=%b exp=0", r, a_bsy1);
            end
        end
        a_rd2 = 2; #1;
        vectors++;
        if (a_rdd2 !== 16'h00AA || a_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL flush_data got=%h cnt=%0d exp=00aa cnt=0", a_rdd2, a_cnt);
        end
    endtask

    task automatic test_fill();
        idle(); b_wen = 1; b_wa = 9; b_wd = 32'h1111_2222; step(); idle();
        for (int r = 1; r < 32; r++) begin
            a_ien = (r < 8); a_ia = 3'(r);
            b_ien = 1;       b_ia = 5'(r);
            step();
        end
        idle(); #1;
        vectors++;
        if (a_cnt !== 4'd7 || b_cnt !== 6'd31) begin
            miscompares++;
            $display("FAIL fill_cnt got=%0d/%0d exp=7/31", a_cnt, b_cnt);
        end
        a_ien = 1; a_ia = 7; step(); idle(); #1;
        vectors++;   // re-issue of a busy register at the maximum: no wrap
        if (a_cnt !== 4'd7) begin
            miscompares++;
            $display("FAIL fill_reissue cnt got=%0d exp=7", a_cnt);
        end
        // BYPASS=0: the register being written reads its old value and busy
        b_wen = 1; b_wa = 9; b_wd = 32'hCAFE_F00D; b_rd1 = 9; #1;
        vectors++;
        if (b_rdd1 !== 32'h1111_2222 || b_bsy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL nobypass got=%h/%b exp=11112222/1", b_rdd1, b_bsy1);
        end
        step(); idle(); #1;
        vectors++;
        if (b_rdd1 !== 32'hCAFE_F00D || b_bsy1 !== 1'b0 || b_cnt !== 6'd30) begin
            miscompares++;
            $display("FAIL nobypass_after got=%h/%b cnt=%0d exp=cafef00d/0 cnt=30", b_rdd1, b_bsy1, b_cnt);
        end
        a_flush = 1; b_flush = 1; step(); idle();
    endtask

    task automatic test_random();
        logic [32:0] e, o;
        rst_n = 0; idle(); step(); rst_n = 1;
        for (int c = 0; c < 600; c++) begin
            rst_n   = ($urandom_range(0, 49) != 0);
            a_wen   = 1'($urandom_range(0, 1)); a_wa = 3'($urandom); a_wd = 16'($urandom);
            a_ien   = 1'($urandom_range(0, 1)); a_ia = 3'($urandom);
            a_flush = ($urandom_range(0, 19) == 0);
            a_rd1   = 3'($urandom); a_rd2 = ($urandom_range(0, 3) == 0) ? a_wa : 3'($urandom);
            b_wen   = 1'($urandom_range(0, 1)); b_wa = 5'($urandom); b_wd = $urandom;
            b_ien   = ($urandom_range(0, 3) != 0); b_ia = 5'($urandom);
            b_flush = ($urandom_range(0, 29) == 0);
            b_rd1   = 5'($urandom); b_rd2 = ($urandom_range(0, 3) == 0) ? b_wa : 5'($urandom);
            #1;
            e = model_rd(0, 5'(a_rd1), a_wen, 5'(a_wa), 32'(a_wd)); o = {a_bsy1, 16'h0, a_rdd1};
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL rnd_a1 cyc=%0d got=%h exp=%h", c, o, e); end
            e = model_rd(0, 5'(a_rd2), a_wen, 5'(a_wa), 32'(a_wd)); o = {a_bsy2, 16'h0, a_rdd2};
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL rnd_a2 cyc=%0d got=%h exp=%h", c, o, e); end
            e = model_rd(1, b_rd1, b_wen, b_wa, b_wd); o = {b_bsy1, b_rdd1};
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL rnd_b1 cyc=%0d got=%h exp=%h", c, o, e); end
            e = model_rd(1, b_rd2, b_wen, b_wa, b_wd); o = {b_bsy2, b_rdd2};
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL rnd_b2 cyc=%0d got=%h exp=%h", c, o, e); end
            vectors++;
            if (int'(a_cnt) != model_cnt(0) || int'(b_cnt) != model_cnt(1)) begin
                miscompares++;
                $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, a_cnt, b_cnt, model_cnt(0), model_cnt(1));
            end
            step();
        end
        rst_n = 1; idle();
    endtask

    initial begin
        idle();
        a_rd1 = 0; a_rd2 = 0; b_rd1 = 0; b_rd2 = 0;
        test_reset();
        test_issue_wb();
        test_collision();
        test_zero_reg();
        test_flush();
        test_fill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file with an integrated per-register scoreboard, for the pipelined core.
- The issue stage marks a destination register pending.
- Writeback writes the data and clears the pending flag.
- Two combinational read ports return data plus a busy flag, so decode can detect RAW hazards; optional write-to-read bypass removes the writeback bubble.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, address width; depth = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes/issues to it ignored), 0 = ordinary register
BYPASS, 1, 1 = same-cycle write data forwarded to read ports, 0 = reads see array contents only

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
rd_addr_1  input  ADDR_W  read port 1 address
rd_addr_2  input  ADDR_W  read port 2 address
rd_data_1  output  DATA_W  read port 1 data (combinational)
rd_data_2  output  DATA_W  read port 2 data (combinational)
rd_busy_1  output  1  register at rd_addr_1 has a pending write
rd_busy_2  output  1  register at rd_addr_2 has a pending write
wr_en  input  1  writeback strobe
wr_addr  input  ADDR_W  writeback destination
wr_data  input  DATA_W  writeback data
iss_en  input  1  issue strobe: mark iss_addr pending
iss_addr  input  ADDR_W  issued destination register
flush  input  1  clear all pending flags (pipeline squash)
busy_cnt  output  ADDR_W+1  number of registers currently pending (registered)

Behaviour:
- Reset (rst_n=0 at posedge):
  - all registers := 0; all busy bits := 0; busy_cnt := 0.
  - wr_en/iss_en/flush ignored that cycle.
  - Reset mid-operation discards all pending state.
- Write: at posedge with wr_en=1, reg[wr_addr] := wr_data, except wr_addr=0 when ZERO_REG=1 (dropped). Writes to a non-busy register are legal and do not change busy_cnt.
- Read, per port, combinational, priority order:
  - (a) ZERO_REG=1 and addr=0 -> data 0, busy 0;
  - (b) BYPASS=1, wr_en=1 and wr_addr=addr (and (a) not hit) -> data = wr_data, busy 0;
  - (c) otherwise data = reg[addr], busy = busy[addr].
  - Both ports may address the same register.
  - With BYPASS=0, a read of the register being written returns the old value and busy as stored.
- Scoreboard update at posedge, per register r, in priority order:
  - flush=1 -> busy[r] := 0 for all r (issue in the same cycle is dropped; a write still updates data);
  - else iss_en=1 and iss_addr=r -> busy[r] := 1 (issue beats a same-cycle writeback to the same register, since a newer producer is in flight);
  - else wr_en=1 and wr_addr=r -> busy[r] := 0;
  - else hold.
  - With ZERO_REG=1, iss_addr=0 is ignored.
- Issue to an already-busy register: stays busy, count unchanged.
- busy_cnt: next value = popcount of next busy vector, maintained incrementally as a counter:
  - +1 when an issue sets a clear bit;
  - -1 when a writeback clears a set bit not re-issued;
  - simultaneous +1/-1 on different registers nets to 0;
  - flush -> 0.
  - Never wraps; maximum is 2**ADDR_W (2**ADDR_W - 1 with ZERO_REG=1).
- Read latency 0; write and scoreboard updates are visible one cycle after the posedge (except via bypass).
- No initialisation from file; reset is the only initialisation.

Test Plan:
- Reset: rst_n=0 one cycle, then read all addresses -> data 0x0000, busy 0, busy_cnt 0.
- Issue/writeback: iss r3 cycle 0 -> rd_busy_1 (addr 3)=1, busy_cnt=1; wr r3=0xBEEF cycle 4 -> same cycle rd_data_1=0xBEEF, busy 0 (bypass); next cycle busy_cnt=0.
- Collision: r5 busy; same cycle iss_en r5 and wr_en r5=0x1234 -> r5 holds 0x1234, busy[5]=1, busy_cnt unchanged (1); cross case iss r2 + wr r5 (r5 busy) -> busy_cnt unchanged.
- Zero register (ZERO_REG=1): wr r0=0xFFFF, iss r0 -> rd r0 data 0, busy 0, busy_cnt 0; with ZERO_REG=0 the same sequence yields 0xFFFF and busy 1.
- Flush: issue r1,r2,r4 (busy_cnt=3); flush with iss r6 and wr r2=0x00AA -> all busy 0, busy_cnt 0, r2=0x00AA, r6 not busy.
- Fill: issue every register 1..7 (defaults) -> busy_cnt=7, no wrap; rerun at DATA_W=32, ADDR_W=5 issuing 1..31 -> busy_cnt=31; BYPASS=0 read of r being written returns old value.
